mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
// - Multi-cycle multiply/divide unit with architectural HI/LO registers; sits in EX beside the ALU and its
//   sign_compare slt path, consuming the same A/B operands from the ID/EX bypass muxes.
// - Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO. Drives busy so hazard logic stalls later MDU instructions.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles for MULT/MULTU, >=1
// - DIV_CYCLES   10  busy cycles for DIV/DIVU, >=1
// PORTS
// - clk      in   1   clock, all state on rising edge
// - reset_n  in   1   asynchronous, active-low reset
// - start    in   1   issue op this cycle (EX-stage valid MDU instruction)
// - op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
// - a        in   32  rs operand (dividend / multiplicand / MT source)
// - b        in   32  rt operand (divisor / multiplier)
// - cancel   in   1   only with MDU_CANCEL_EN: exception flush of the EX instruction
// - busy     out  1   registered; high while an op is in flight
// - hi       out  32  HI register
// - lo       out  32  LO register
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE, counter 0, busy 0, hi 0, lo 0, pending regs 0; abandons any op.
// - FSM IDLE/RUN. IDLE + start + op 0-3: latch result into pend_hi/pend_lo at that edge, load counter
//   with MULT_CYCLES or DIV_CYCLES, go RUN, busy=1 from next cycle.
// - RUN: counter decrements each cycle; on the edge where counter==1, hi<=pend_hi, lo<=pend_lo,
//   busy<=0, go IDLE. Start at edge k -> busy cycles k+1..k+N, new HI/LO visible in cycle k+N+1.
// - start while busy=1: ignored entirely (hazard unit must stall; not an error).
// - IDLE + start + MTHI: hi<=a next edge, busy stays 0; MTLO likewise for lo. Reserved ops: no effect.
// - hi/lo hold old values throughout RUN; they never expose a partial result.
// - MULT: signed 32x32 -> 64, {hi,lo}=product. MULTU: unsigned.
// - DIV: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//   0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU: unsigned quotient/remainder.
// - Divide by zero (b==0, DIV or DIVU): runs full DIV_CYCLES, busy as normal, hi/lo left unchanged.
// - Operands sampled only at the start edge; later a/b changes have no effect.
// CONFIGURATION
// - MDU_CANCEL_EN defined: cancel port exists. cancel with start in IDLE suppresses the start
//   (no MT write, no RUN). cancel during RUN: go IDLE next edge, busy<=0, hi/lo unchanged, pending dropped.
// - MDU_CANCEL_EN undefined: no cancel port; in-flight ops always commit.
// STRUCTURE
// - mdu_pkg: op encodings (MDU_MULT..MDU_MTLO), state encoding (S_IDLE, S_RUN), default cycle counts.
// - Sub-module mdu_div_core: combinational signed/unsigned 32-bit quotient/remainder with
//   the sign fix-up and INT_MIN/-1 rule; mdu_unit owns FSM, counter, pending and HI/LO regs.
// - Counter width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
// TESTING
// - MULT a=0xFFFFFFFF b=2 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
// - MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 busy cycles.
// - DIV a=-7 b=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/2 -> lo=3 hi=1.
// - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU b=0 -> hi/lo unchanged, busy 10 cycles.
// - MTHI a=0x12345678 -> hi next cycle, busy never 1; start MULT during busy -> ignored, hi/lo from first op.
// - reset_n low mid-DIV -> busy, hi, lo 0 immediately; with MDU_CANCEL_EN, cancel at cycle 3 of MULT -> hi/lo old.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and cycle defaults for the MDU
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  // Instruction encodings on the op input; 6 and 7 are reserved
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

  // Sequencer states
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Default latencies in busy cycles
  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Larger of two latencies, used to size the cycle counter
  function automatic int mdu_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - issue/result bundle between EX stage and MDU (cancel present with MDU_CANCEL_EN)
interface mdu_if;
  import mdu_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] op;
  logic [31:0]         a;
  logic [31:0]         b;
`ifdef MDU_CANCEL_EN
  logic                cancel;
`endif
  logic                busy;
  logic [31:0]         hi;
  logic [31:0]         lo;

`ifdef MDU_CANCEL_EN
  modport master (output start, op, a, b, cancel, input busy, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
`else
  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
`endif

endinterface

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - combinational 32-bit signed/unsigned quotient and remainder
module mdu_div_core (
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. INT_MIN / -1 yields magnitude 0x80000000
  // with no sign flip, so the quotient wraps to 0x80000000 and remainder is 0.
  // A zero divisor is replaced by 1 purely to keep the datapath X-free; the
  // caller discards the result via div_zero.
  always_comb begin
    div_zero  = (divisor == 32'd0);
    a_neg     = is_signed & dividend[31];
    b_neg     = is_signed & divisor[31];
    a_mag     = a_neg ? (32'd0 - dividend) : dividend;
    b_mag     = b_neg ? (32'd0 - divisor) : divisor;
    b_safe    = div_zero ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    remainder = a_neg ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle MULT/DIV unit with HI/LO registers; MDU_CANCEL_EN adds exception cancel
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset_n,
  mdu_if.slave  bus
);

  localparam int CNT_W = $clog2(mdu_max(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = MULT_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DIV_LOAD  = DIV_CYCLES[CNT_W-1:0];

  logic [0:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic [31:0]      hi_q,      hi_d;
  logic [31:0]      lo_q,      lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic             cancel_in;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      div_q;
  logic [31:0]      div_r;
  logic             div_zero;

`ifdef MDU_CANCEL_EN
  assign cancel_in = bus.cancel;
`else
  assign cancel_in = 1'b0;
`endif

  mdu_div_core u_div (
    .is_signed (bus.op == MDU_DIV),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .quotient  (div_q),
    .remainder (div_r),
    .div_zero  (div_zero)
  );

  // Full 64-bit products of the issuing operands, signed and unsigned
  always_comb begin
    prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    prod_u = {32'd0, bus.a} * {32'd0, bus.b};
  end

  // Sequencer: capture result at issue, count down the latency, then commit to HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !cancel_in) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU: begin
              {pend_hi_d, pend_lo_d} = (bus.op == MDU_MULT) ? prod_s : prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              // Divide by zero still occupies the unit but never commits
              pend_hi_d = div_r;
              pend_lo_d = div_q;
              pend_wr_d = !div_zero;
              cnt_d     = DIV_LOAD;
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            MDU_MTHI: hi_d = bus.a;
            MDU_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // New issues are ignored here; the hazard unit is expected to stall
        if (cancel_in) begin
          pend_wr_d = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_wr_d = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any in-flight op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed and random checks of mdu_unit against an arithmetic model
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one op computed with plain 64-bit arithmetic
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    int              a32, b32;
    longint          sa, sb, sq, sr, sp;
    longint unsigned up;
    a32 = a;
    b32 = b;
    sa  = a32;
    sb  = b32;
    cyc = 0;
    case (op)
      3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; cyc = MC; end
      3'd1: begin up = 64'(a) * 64'(b); m_hi = up[63:32]; m_lo = up[31:0]; cyc = MC; end
      3'd2: begin
        cyc = DC;
        if (b != 0) begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      3'd3: begin
        cyc = DC;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, scramble operands afterwards, optionally try a second start while busy
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit inject);
    logic [31:0] old_hi, old_lo;
    int exp_cyc;
    int cyc;
    bit stable;
    old_hi = m_hi;
    old_lo = m_lo;
    cyc    = 0;
    stable = 1'b1;
    model(op, a, b, exp_cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom_range(0, 3));
    while (bus.busy === 1'b1 && cyc < 64) begin
      if (bus.hi !== old_hi || bus.lo !== old_lo) stable = 1'b0;
      cyc++;
      bus.start = (inject && cyc == 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " hold"}, 64'(stable), 64'd1);
    check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
`ifdef MDU_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    reset_n = 1'b1;

    issue("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mult_neg1x2 const_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg1x2 const_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
    issue("multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu const_hi", 64'(bus.hi), 64'h1);
    issue("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2 const_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check("div_m7_2 const_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    issue("divu_7_2", 3'd3, 32'd7, 32'd2, 1'b0);
    check("divu_7_2 const_lo", 64'(bus.lo), 64'd3);
    issue("div_intmin", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_intmin const_lo", 64'(bus.lo), 64'h8000_0000);
    check("div_intmin const_hi", 64'(bus.hi), 64'd0);
    issue("div_by0", 3'd2, 32'd123, 32'd0, 1'b0);
    issue("divu_by0", 3'd3, 32'd55, 32'd0, 1'b0);
    issue("mthi", 3'd4, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi const", 64'(bus.hi), 64'h1234_5678);
    issue("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
    issue("reserved6", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    issue("reserved7", 3'd7, 32'hBEEF_DEAD, 32'd1, 1'b0);
    issue("mult_during_busy", 3'd0, 32'd3, 32'd4, 1'b1);
    issue("div_during_busy", 3'd3, 32'd100, 32'd9, 1'b1);

    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
      issue("rand", r_op, r_a, r_b, (r_op < 3'd4) && ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of a divide clears everything immediately
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd1000; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid busy", 64'(bus.busy), 64'd0);
    check("rst_mid hi", 64'(bus.hi), 64'd0);
    check("rst_mid lo", 64'(bus.lo), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    issue("after_rst", 3'd1, 32'd6, 32'd7, 1'b0);

`ifdef MDU_CANCEL_EN
    // Cancel on cycle 3 of a multiply drops the result
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd99; bus.b = 32'd99;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel busy", 64'(bus.busy), 64'd0);
    check("cancel hi", 64'(bus.hi), 64'(m_hi));
    check("cancel lo", 64'(bus.lo), 64'(m_lo));
    // Cancel alongside an MTHI issue suppresses the write
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hAAAA_5555; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cancel_mthi hi", 64'(bus.hi), 64'(m_hi));
    check("cancel_mthi busy", 64'(bus.busy), 64'd0);
    issue("after_cancel", 3'd2, 32'hFFFF_FF00, 32'd3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
